// File: rtl/uart_pkg.sv
// uart_pkg: UART constants, FSM state type and baud divisor helper shared by TX and future RX.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP = 1'b1;
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: generic synchronous FIFO; ports clock_50mhz, reset_pin (async, active-low), push/din, pop/dout, count, full, empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock_50mhz,
  input  logic                       reset_pin,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clock_50mhz)
    if (do_push) mem[wr_ptr] <= din;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock_50mhz or negedge reset_pin)
    if (!reset_pin) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8N1 UART transmitter.
// Ports: clock_50mhz, reset_pin (async, active-low); tx_data/tx_valid/tx_ready byte handshake into a FIFO;
// tx_pin serial line (registered, idle high); busy; tx_done end-of-frame pulse; fifo_count occupancy.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                          clock_50mhz,
  input  logic                          reset_pin,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_pin,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW = $clog2(DIV);
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_buffered: baud divisor must be at least 2");
  end
  tx_state_t state;
  logic [CW-1:0] baud_cnt;
  logic [UART_DATA_BITS-1:0] shreg, head;
  logic [2:0] idx;
  logic full, empty, terminal, frame_end, pop;
  assign tx_ready = !full;
  assign terminal = baud_cnt == CW'(DIV - 1);
  // idx also counts stop bits, so multi-stop frames reuse the per-bit counter.
  assign frame_end = state == STOP && terminal && idx == 3'(STOP_BITS - 1);
  // Pop from IDLE or straight out of the last stop bit, giving back-to-back frames.
  assign pop = !empty && (state == IDLE || frame_end);
  uart_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock_50mhz(clock_50mhz),
    .reset_pin(reset_pin),
    .push(tx_valid && tx_ready),
    .pop(pop),
    .din(tx_data),
    .dout(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clock_50mhz or negedge reset_pin)
    if (!reset_pin) begin
      state <= IDLE;
      baud_cnt <= '0;
      shreg <= '0;
      idx <= '0;
      tx_pin <= LINE_IDLE;
      tx_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      tx_done <= frame_end;
      busy <= state != IDLE || !empty;
      if (pop) begin
        shreg <= head;
        baud_cnt <= '0;
        idx <= '0;
        state <= START;
        tx_pin <= LINE_START;
      end else if (state != IDLE) begin
        baud_cnt <= terminal ? '0 : baud_cnt + 1'b1;
        if (terminal)
          case (state)
            START: begin
              state <= DATA;
              idx <= '0;
              tx_pin <= shreg[0];
            end
            DATA:
              if (idx == 3'(UART_DATA_BITS - 1)) begin
                state <= STOP;
                idx <= '0;
                tx_pin <= LINE_STOP;
              end else begin
                shreg <= shreg >> 1;
                idx <= idx + 1'b1;
                tx_pin <= shreg[1];
              end
            STOP:
              if (frame_end) state <= IDLE;
              else idx <= idx + 1'b1;
            default: state <= IDLE;
          endcase
      end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed checks of the buffered UART transmitter at default and 9600/2-stop settings.
module tb_uart_tx_buffered;
  localparam int DIV = 434;
  localparam int DIV2 = 5208;
  logic clk = 0;
  logic reset_pin, reset2;
  logic [7:0] tx_data, tx_data2;
  logic tx_valid, tx_valid2;
  logic tx_ready, tx_pin, busy, tx_done;
  logic tx_ready2, tx_pin2, busy2, tx_done2;
  logic [2:0] fifo_count, fifo_count2;
  int vectors = 0;
  int miscompares = 0;
  int bad;

  always #10 clk = ~clk;

  uart_tx_buffered dut (
    .clock_50mhz(clk), .reset_pin(reset_pin), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_pin(tx_pin), .busy(busy), .tx_done(tx_done), .fifo_count(fifo_count)
  );

  uart_tx_buffered #(.BAUD(9600), .STOP_BITS(2)) dut2 (
    .clock_50mhz(clk), .reset_pin(reset2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx_pin(tx_pin2), .busy(busy2), .tx_done(tx_done2), .fifo_count(fifo_count2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walk a frame from bit-time t0 to t1, checking the line at the first and last cycle of every bit.
  task automatic frame(input bit sel, input logic [7:0] b, input int div, input int nbits,
                       input int t0, input int t1, input bit tog);
    int k;
    logic e;
    for (int t = t0; t < t1; t++) begin
      k = t / div;
      e = (k == 0) ? 1'b0 : (k <= 8) ? b[3'(k - 1)] : 1'b1;
      if (tog) tx_data = ~tx_data;
      if (t % div == 0 || t % div == div - 1) chk(sel ? "pin2" : "pin", sel ? tx_pin2 : tx_pin, e);
      if (t == nbits * div - 1) chk(sel ? "done2_early" : "done_early", sel ? tx_done2 : tx_done, 0);
      tick();
    end
    if (t1 == nbits * div) chk(sel ? "done2" : "done", sel ? tx_done2 : tx_done, 1);
  endtask

  initial begin
    reset_pin = 0; reset2 = 0;
    tx_valid = 0; tx_data = 0; tx_valid2 = 0; tx_data2 = 0;
    repeat (3) tick();
    chk("rst_pin", tx_pin, 1);
    chk("rst_done", tx_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", tx_ready, 1);
    reset_pin = 1; reset2 = 1;
    tick();
    chk("idle_pin", tx_pin, 1);
    fork
      begin
        tx_data2 = 8'hA5; tx_valid2 = 1;
        tick();
        tx_valid2 = 0;
        tick();
        frame(1, 8'hA5, DIV2, 11, 0, 11 * DIV2, 0);
        chk("a5_idle", tx_pin2, 1);
        chk("a5_count", fifo_count2, 0);
      end
      begin
        // single byte 0x41
        tx_data = 8'h41; tx_valid = 1;
        tick();
        chk("41_count", fifo_count, 1);
        chk("41_pre", tx_pin, 1);
        tx_valid = 0;
        tick();
        chk("41_busy", busy, 1);
        frame(0, 8'h41, DIV, 10, 0, 10 * DIV, 0);
        chk("41_end_pin", tx_pin, 1);
        chk("41_end_busy", busy, 1);
        tick();
        chk("41_busy_clr", busy, 0);
        chk("41_done_clr", tx_done, 0);
        // held valid, bytes 0x30..0x35
        tx_valid = 1;
        tx_data = 8'h30; chk("q_rdy0", tx_ready, 1); tick();
        tx_data = 8'h31; chk("q_rdy1", tx_ready, 1); tick();
        chk("q_cnt1", fifo_count, 1);
        tx_data = 8'h32; tick();
        tx_data = 8'h33; tick();
        tx_data = 8'h34; tick();
        chk("q_full", fifo_count, 4);
        chk("q_rdy_low", tx_ready, 0);
        tx_data = 8'h35;
        frame(0, 8'h30, DIV, 10, 3, 10 * DIV, 0);
        chk("q_gap0", tx_pin, 0);
        chk("q_cnt3", fifo_count, 3);
        chk("q_rdy_back", tx_ready, 1);
        tick();
        chk("q_cnt4", fifo_count, 4);
        tx_valid = 0;
        frame(0, 8'h31, DIV, 10, 1, 10 * DIV, 0);
        chk("q_gap1", tx_pin, 0);
        frame(0, 8'h32, DIV, 10, 0, 10 * DIV, 0);
        chk("q_gap2", tx_pin, 0);
        frame(0, 8'h33, DIV, 10, 0, 10 * DIV, 0);
        chk("q_gap3", tx_pin, 0);
        frame(0, 8'h34, DIV, 10, 0, 10 * DIV, 0);
        chk("q_gap4", tx_pin, 0);
        chk("q_cnt0", fifo_count, 0);
        frame(0, 8'h35, DIV, 10, 0, 10 * DIV, 0);
        chk("q_end_pin", tx_pin, 1);
        tick();
        chk("q_busy_clr", busy, 0);
        // reset mid-frame with 3 queued
        tx_valid = 1;
        tx_data = 8'h55; tick();
        tx_data = 8'hAA; tick();
        tx_data = 8'hBB; tick();
        tx_data = 8'hCC; tick();
        tx_valid = 0;
        chk("r_cnt3", fifo_count, 3);
        repeat (1998) tick();
        chk("r_bit3", tx_pin, 0);
        reset_pin = 0;
        #1;
        chk("r_pin", tx_pin, 1);
        chk("r_cnt", fifo_count, 0);
        chk("r_busy", busy, 0);
        chk("r_ready", tx_ready, 1);
        #2 reset_pin = 1;
        bad = 0;
        repeat (1000) begin
          tick();
          if (tx_pin !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
        end
        chk("r_silent", bad, 0);
        tx_data = 8'h12; tx_valid = 1;
        tick();
        tx_valid = 0;
        tick();
        frame(0, 8'h12, DIV, 10, 0, 10 * DIV, 0);
        chk("r_12_end", tx_pin, 1);
        // tx_data toggling, push/pop coincidence
        tx_data = 8'h0F; tx_valid = 1;
        tick();
        tx_data = 8'h9C;
        tick();
        chk("c_cnt_idle", fifo_count, 1);
        tx_valid = 0;
        frame(0, 8'h0F, DIV, 10, 0, 10 * DIV - 1, 1);
        tx_data = 8'hE7; tx_valid = 1;
        chk("c_cnt_pre", fifo_count, 1);
        frame(0, 8'h0F, DIV, 10, 10 * DIV - 1, 10 * DIV, 0);
        tx_valid = 0;
        chk("c_cnt_stop", fifo_count, 1);
        chk("c_gap", tx_pin, 0);
        frame(0, 8'h9C, DIV, 10, 0, 10 * DIV, 0);
        chk("c_gap2", tx_pin, 0);
        frame(0, 8'hE7, DIV, 10, 0, 10 * DIV, 0);
        chk("c_end", tx_pin, 1);
        chk("c_cnt0", fifo_count, 0);
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
